// File: rtl/queue_sink_if.sv
// queue_sink_if -- handshake bundle between a queue producer/consumer and
// queue_sink_module.
//   master : drives wr/input_1 (producer) and rd (consumer), observes status
//   slave  : the FIFO itself; returns output_1/valid and empty/full/count/overflow
interface queue_sink_if #(
  parameter int BITS_NUMBER   = 16,
  parameter int FIFO_ELEMENTS = 5
);
  logic                   wr;
  logic [BITS_NUMBER-1:0] input_1;
  logic                   rd;
  logic [BITS_NUMBER-1:0] output_1;
  logic                   valid;
  logic                   empty;
  logic                   full;
  logic [FIFO_ELEMENTS:0] count;
  logic                   overflow;

  modport master (
    output wr, input_1, rd,
    input  output_1, valid, empty, full, count, overflow
  );

  modport slave (
    input  wr, input_1, rd,
    output output_1, valid, empty, full, count, overflow
  );
endinterface

// File: rtl/queue_sink_module.sv
// queue_sink_module -- synchronous FIFO sink of 2**FIFO_ELEMENTS words.
//   clk    : single clock, rising edge
//   reset  : synchronous, active-high
//   bus    : queue_sink_if.slave
//            wr/input_1 write side, rd read request,
//            output_1/valid registered read data with a one-cycle valid pulse,
//            empty/full/count occupancy, overflow sticky dropped-write flag
module queue_sink_module #(
  parameter int BITS_NUMBER   = 16,
  parameter int FIFO_ELEMENTS = 5
) (
  input  logic         clk,
  input  logic         reset,
  queue_sink_if.slave  bus
);

  localparam int DEPTH = 1 << FIFO_ELEMENTS;
  localparam logic [FIFO_ELEMENTS-1:0] PTR_ONE  = {{(FIFO_ELEMENTS-1){1'b0}}, 1'b1};
  localparam logic [FIFO_ELEMENTS:0]   CNT_ONE  = {{FIFO_ELEMENTS{1'b0}}, 1'b1};
  localparam logic [FIFO_ELEMENTS:0]   CNT_FULL = {1'b1, {FIFO_ELEMENTS{1'b0}}};

  logic [BITS_NUMBER-1:0]   mem [DEPTH];

  // Declaration initialisers give simulation power-up values equal to reset.
  logic [FIFO_ELEMENTS-1:0] w_ptr    = '0;
  logic [FIFO_ELEMENTS-1:0] r_ptr    = '0;
  logic [FIFO_ELEMENTS:0]   cnt      = '0;
  logic [BITS_NUMBER-1:0]   out_q    = '0;
  logic                     valid_q  = 1'b0;
  logic                     ovf_q    = 1'b0;

  logic empty_w, full_w, rd_acc, wr_acc;

  // Flags decode straight from the registered count so they line up with it.
  assign empty_w = (cnt == '0);
  assign full_w  = (cnt == CNT_FULL);

  // A read never falls through an empty FIFO; a write at full is only taken
  // when a read frees a slot in the same cycle.
  assign rd_acc  = bus.rd & ~empty_w;
  assign wr_acc  = bus.wr & (~full_w | rd_acc);

  // Array is not reset; stale words stay unreachable because r_ptr can only
  // reach slots that were written since the last reset.
  always_ff @(posedge clk) begin
    if (wr_acc && !reset) mem[w_ptr] <= bus.input_1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_ptr   <= '0;
      r_ptr   <= '0;
      cnt     <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= rd_acc;
      if (wr_acc) w_ptr <= w_ptr + PTR_ONE;
      if (rd_acc) begin
        out_q <= mem[r_ptr];
        r_ptr <= r_ptr + PTR_ONE;
      end
      case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
      if (bus.wr && !wr_acc) ovf_q <= 1'b1;
    end
  end

  assign bus.output_1 = out_q;
  assign bus.valid    = valid_q;
  assign bus.empty    = empty_w;
  assign bus.full     = full_w;
  assign bus.count    = cnt;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_queue_sink_module.sv
// tb_queue_sink_module -- directed edge cases plus randomized traffic, checked
// against a queue-based reference model of the sink.
module tb_queue_sink_module;
  localparam int BW   = 16;
  localparam int FE   = 5;
  localparam int DEP  = 1 << FE;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  queue_sink_if #(.BITS_NUMBER(BW), .FIFO_ELEMENTS(FE)) bus ();

  queue_sink_module #(.BITS_NUMBER(BW), .FIFO_ELEMENTS(FE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state
  logic [BW-1:0] mq[$];
  logic [BW-1:0] m_out   = '0;
  logic          m_valid = 1'b0;
  logic          m_ovf   = 1'b0;
  int            wr_total = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out"},   32'(bus.output_1), 32'(m_out));
    chk({tag, ".valid"}, 32'(bus.valid),    32'(m_valid));
    chk({tag, ".count"}, 32'(bus.count),    32'(mq.size()));
    chk({tag, ".empty"}, 32'(bus.empty),    32'(mq.size() == 0));
    chk({tag, ".full"},  32'(bus.full),     32'(mq.size() == DEP));
    chk({tag, ".ovf"},   32'(bus.overflow), 32'(m_ovf));
  endtask

  // One clock: drive on the falling edge, step the model at the rising edge,
  // compare shortly after.
  task automatic cycle(input string tag, input logic r, input logic w,
                       input logic rd, input logic [BW-1:0] d);
    logic ra, wa;
    @(negedge clk);
    reset = r; bus.wr = w; bus.rd = rd; bus.input_1 = d;
    @(posedge clk);
    if (r) begin
      mq.delete(); m_out = '0; m_valid = 1'b0; m_ovf = 1'b0;
    end else begin
      ra = rd && (mq.size() > 0);
      wa = w && ((mq.size() < DEP) || ra);
      m_valid = ra;
      if (ra) m_out = mq.pop_front();
      if (wa) begin mq.push_back(d); wr_total++; end
      if (w && !wa) m_ovf = 1'b1;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    bus.wr = 1'b0; bus.rd = 1'b0; bus.input_1 = '0;
    #1;
    check_all("powerup");

    cycle("reset", 1, 0, 0, '0);

    // Basic ordering
    for (int i = 1; i <= 3; i++) cycle("basic_wr", 0, 1, 0, BW'(i));
    for (int i = 0; i < 3; i++)  cycle("basic_rd", 0, 0, 1, '0);
    cycle("basic_idle", 0, 0, 0, '0);

    // Fill then one write past full, then drain past empty
    cycle("reset", 1, 0, 0, '0);
    for (int i = 0; i < 33; i++) cycle("fill_wr", 0, 1, 0, BW'(16'h0100 + i));
    for (int i = 0; i < 33; i++) cycle("fill_rd", 0, 0, 1, '0);

    // Simultaneous read/write at full
    cycle("reset", 1, 0, 0, '0);
    for (int i = 0; i < 32; i++) cycle("fs_wr", 0, 1, 0, BW'(16'h0200 + i));
    cycle("fs_both", 0, 1, 1, 16'hBEEF);
    for (int i = 0; i < 32; i++) cycle("fs_rd", 0, 0, 1, '0);

    // Empty edge cases (output_1 holds the last drained word here)
    cycle("em_rd", 0, 0, 1, '0);
    cycle("em_both", 0, 1, 1, 16'h00AA);
    cycle("em_rd2", 0, 0, 1, '0);
    cycle("em_idle", 0, 0, 0, '0);

    // Reset with a read in flight
    for (int i = 0; i < 10; i++) cycle("rst_wr", 0, 1, 0, BW'($urandom));
    cycle("rst_rd_rst", 1, 0, 1, '0);
    cycle("rst_after", 0, 1, 0, 16'h0055);
    cycle("rst_rd", 0, 0, 1, '0);
    cycle("rst_idle", 0, 0, 0, '0);

    // Wrap-around: count kept inside 1..31 with heavy traffic
    cycle("wrap_seed", 0, 1, 0, BW'($urandom));
    wr_total = 0;
    for (int i = 0; i < 300; i++) begin
      logic w, r;
      w = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 3) != 0);
      if (mq.size() >= 31) w = 1'b0;
      if (mq.size() <= 1)  r = 1'b0;
      cycle("wrap", 0, w, r, BW'($urandom));
    end
    chk("wrap_twice", 32'(wr_total >= 2 * DEP), 32'd1);

    // Unconstrained traffic including full/empty/overflow and sporadic reset
    for (int i = 0; i < 400; i++) begin
      logic r;
      r = ($urandom_range(0, 99) == 0);
      cycle("rand", r, 1'($urandom), 1'($urandom), BW'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
